// File: rtl/wei_ram_fetch_pkg.sv
// Shared definitions for the weight-RAM fetch path: sequencer states and output buffer depth.
package pe_pkg;

   localparam int unsigned FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_ZDONE = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/wei_ram_fetch_fifo.sv
// Two-entry register FIFO buffering RAM read data; push and pop in the same cycle are legal even when full.
module wei_skid_fifo
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH = 29
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == 2'(FIFO_DEPTH));
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wei_ram_fetch.sv
// Weight RAM read sequencer: issues credit-limited reads, absorbs the 1-cycle RAM latency,
// and streams the words to the PE as valid/ready with a last marker.
module wei_ram_fetch
   import pe_pkg::*;
#(
   parameter int unsigned SRAM_DEPTH_BIT = 6,
   parameter int unsigned SRAM_DEPTH     = 64,
   parameter int unsigned SRAM_WIDTH     = 28
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_start,
   input  logic [SRAM_DEPTH_BIT-1:0] cfg_base_addr,
   input  logic [SRAM_DEPTH_BIT:0]   cfg_len,
   input  logic                      ram_wr_busy,
   output logic                      ram_read_en,
   output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
   input  logic [SRAM_WIDTH-1:0]     ram_data_out,
   output logic                      wei_vld,
   input  logic                      wei_rdy,
   output logic [SRAM_WIDTH-1:0]     wei_data,
   output logic                      wei_last,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned CW = SRAM_DEPTH_BIT + 1;

   fetch_state_e              r_state;
   fetch_state_e              w_state_nxt;
   logic [SRAM_DEPTH_BIT-1:0] r_base;
   logic [CW-1:0]             r_len;
   logic [CW-1:0]             r_issued;
   logic [CW-1:0]             r_returned;
   logic                      r_rd_pend;

   logic [CW-1:0]             w_len_m1;
   logic                      w_start_fetch;
   logic                      w_read_en;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_push_last;
   logic [SRAM_WIDTH:0]       w_head;
   logic                      w_head_last;
   logic                      w_fifo_full;
   logic                      w_fifo_empty;
   logic [1:0]                w_fifo_cnt;
   logic [2:0]                w_occ;
   logic                      w_done;

   assign w_len_m1      = r_len - CW'(1);
   assign w_start_fetch = (r_state == S_IDLE) & cfg_start & (cfg_len != '0);

   // Credit is judged after this cycle's pop so a steady 1-word-per-cycle stream needs only two slots.
   assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
   assign w_read_en = (r_state == S_FETCH) & ~ram_wr_busy & (w_occ < 3'(FIFO_DEPTH));

   assign w_push      = r_rd_pend;
   assign w_push_last = (r_returned == w_len_m1);
   assign w_head_last = w_head[SRAM_WIDTH];
   assign w_pop       = wei_vld & wei_rdy;

   assign ram_read_en = w_read_en;
   assign ram_addr_r  = r_base + r_issued[SRAM_DEPTH_BIT-1:0];
   assign wei_vld     = ~w_fifo_empty;
   assign wei_data    = w_head[SRAM_WIDTH-1:0];
   assign wei_last    = wei_vld & w_head_last;
   assign busy        = (r_state == S_FETCH) | (r_state == S_DRAIN);
   assign done        = w_done;

   wei_skid_fifo #(
      .WIDTH (SRAM_WIDTH + 1)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({w_push_last, ram_data_out}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_cnt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cfg_start) begin
               w_state_nxt = (cfg_len == '0) ? S_ZDONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_read_en && (r_issued == w_len_m1)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && w_head_last) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ZDONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_returned <= '0;
         r_rd_pend  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= w_read_en;
         if (w_start_fetch) begin
            r_base     <= cfg_base_addr;
            r_len      <= cfg_len;
            r_issued   <= '0;
            r_returned <= '0;
         end else begin
            if (w_read_en) r_issued <= r_issued + CW'(1);
            if (w_push)    r_returned <= r_returned + CW'(1);
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && w_fifo_full && !w_pop));

   a_len_range: assert property (@(posedge clk) disable iff (!rst_n)
      (w_start_fetch |-> (cfg_len <= CW'(SRAM_DEPTH))));

endmodule

// File: tb/tb_wei_ram_fetch.sv
// Self-checking bench for wei_ram_fetch with a 1-cycle-latency RAM model holding mem[i] = i.
module tb_wei_ram_fetch;

   localparam int DB = 6;
   localparam int SW = 28;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start;
   logic [DB-1:0] cfg_base_addr;
   logic [DB:0]   cfg_len;
   logic          ram_wr_busy;
   logic          ram_read_en;
   logic [DB-1:0] ram_addr_r;
   logic [SW-1:0] ram_data_out;
   logic          wei_vld;
   logic          wei_rdy;
   logic [SW-1:0] wei_data;
   logic          wei_last;
   logic          busy;
   logic          done;

   logic [SW-1:0] mem [64];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_read_en) ram_data_out <= mem[ram_addr_r];
   end

   wei_ram_fetch #(
      .SRAM_DEPTH_BIT (6),
      .SRAM_DEPTH     (64),
      .SRAM_WIDTH     (28)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start     (cfg_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_len       (cfg_len),
      .ram_wr_busy   (ram_wr_busy),
      .ram_read_en   (ram_read_en),
      .ram_addr_r    (ram_addr_r),
      .ram_data_out  (ram_data_out),
      .wei_vld       (wei_vld),
      .wei_rdy       (wei_rdy),
      .wei_data      (wei_data),
      .wei_last      (wei_last),
      .busy          (busy),
      .done          (done)
   );

   typedef struct {
      int unsigned base;
      int unsigned len;
      logic [15:0] rdy_pat;
      int unsigned wb_start;
      int unsigned wb_len;
      bit          restart;
      int unsigned exp_first;
      int unsigned exp_last;
      int          exp_span;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int unsigned issued = 0;
      int unsigned got = 0;
      int first_c = -1;
      int last_c = -1;
      int unsigned first_data = 0;
      int unsigned last_data = 0;
      bit fin = 0;
      bit prev_stall = 0;
      logic [SW-1:0] prev_data = '0;
      @(negedge clk);
      cfg_start     = 1'b1;
      cfg_base_addr = v.base[DB-1:0];
      cfg_len       = v.len[DB:0];
      wei_rdy       = 1'b0;
      ram_wr_busy   = 1'b0;
      #1;
      chk("busy_before_start", busy, 0);
      @(posedge clk);
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         cfg_start = v.restart && (c == 3);
         if (cfg_start) begin
            cfg_base_addr = 6'd50;
            cfg_len       = 7'd3;
         end
         wei_rdy     = v.rdy_pat[c % 16];
         ram_wr_busy = (c >= int'(v.wb_start)) && (c < int'(v.wb_start + v.wb_len));
         #1;
         chk("busy_active", busy, 1);
         if (ram_wr_busy) chk("read_during_wr_busy", ram_read_en, 0);
         if (ram_read_en) begin
            chk("read_addr", ram_addr_r, (v.base + issued) % 64);
            issued++;
         end
         if (wei_vld && wei_rdy) begin
            chk("data", wei_data, (v.base + got) % 64);
            chk("last_flag", wei_last, (got == v.len - 1));
            chk("done_on_last", done, (got == v.len - 1));
            if (got == 0) begin
               first_c    = c;
               first_data = wei_data;
            end
            if (got == v.len - 1) begin
               last_c    = c;
               last_data = wei_data;
               fin       = 1;
            end
            got++;
         end else begin
            chk("done_quiet", done, 0);
         end
         chk("outstanding_le2", (issued - got) <= 2, 1);
         if (prev_stall) begin
            chk("vld_hold", wei_vld, 1);
            chk("data_hold", wei_data, prev_data);
         end
         prev_stall = wei_vld && !wei_rdy;
         prev_data  = wei_data;
      end
      cfg_start = 1'b0;
      if (!fin) chk("txn_timeout", 0, 1);
      chk("word_count", got, v.len);
      chk("read_count", issued, v.len);
      chk("first_word", first_data, v.exp_first);
      chk("last_word", last_data, v.exp_last);
      if (v.exp_span >= 0) chk("stream_span", last_c - first_c, v.exp_span);
      @(negedge clk);
      wei_rdy     = 1'b0;
      ram_wr_busy = 1'b0;
      #1;
      chk("busy_after_done", busy, 0);
      chk("done_after", done, 0);
      chk("vld_after", wei_vld, 0);
      chk("read_after", ram_read_en, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t rv;
      for (int i = 0; i < 64; i++) mem[i] = SW'(i);
      vecs[0] = '{base: 0,  len: 4,  rdy_pat: 16'hFFFF, wb_start: 0, wb_len: 0, restart: 0, exp_first: 0,  exp_last: 3,  exp_span: 3};
      vecs[1] = '{base: 62, len: 4,  rdy_pat: 16'hFFFF, wb_start: 0, wb_len: 0, restart: 0, exp_first: 62, exp_last: 1,  exp_span: 3};
      vecs[2] = '{base: 5,  len: 8,  rdy_pat: 16'h9999, wb_start: 0, wb_len: 0, restart: 0, exp_first: 5,  exp_last: 12, exp_span: -1};
      vecs[3] = '{base: 10, len: 6,  rdy_pat: 16'hFFFF, wb_start: 2, wb_len: 3, restart: 1, exp_first: 10, exp_last: 15, exp_span: -1};
      vecs[4] = '{base: 17, len: 64, rdy_pat: 16'hFFFF, wb_start: 0, wb_len: 0, restart: 0, exp_first: 17, exp_last: 16, exp_span: 63};
      vecs[5] = '{base: 40, len: 1,  rdy_pat: 16'h5555, wb_start: 0, wb_len: 0, restart: 0, exp_first: 40, exp_last: 40, exp_span: -1};

      rst_n         = 1'b0;
      cfg_start     = 1'b0;
      cfg_base_addr = '0;
      cfg_len       = '0;
      ram_wr_busy   = 1'b0;
      wei_rdy       = 1'b0;
      ram_data_out  = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_vld", wei_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_read_en", ram_read_en, 0);
      chk("rst_last", wei_last, 0);
      chk("rst_data", wei_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);

      // Zero-length command: done one cycle after start, no busy, no reads.
      @(negedge clk);
      cfg_start     = 1'b1;
      cfg_base_addr = 6'd7;
      cfg_len       = 7'd0;
      wei_rdy       = 1'b1;
      #1;
      chk("z_done_pre", done, 0);
      chk("z_read_pre", ram_read_en, 0);
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_read", ram_read_en, 0);
      @(negedge clk);
      #1;
      chk("z_done_clear", done, 0);
      chk("z_busy_after", busy, 0);
      chk("z_read_after", ram_read_en, 0);
      chk("z_vld_after", wei_vld, 0);

      // Reset with a word buffered and a read in flight.
      @(negedge clk);
      cfg_start     = 1'b1;
      cfg_base_addr = 6'd0;
      cfg_len       = 7'd8;
      wei_rdy       = 1'b0;
      @(negedge clk);
      cfg_start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("pre_rst_vld", wei_vld, 1);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", wei_vld, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_read", ram_read_en, 0);
      chk("mid_rst_last", wei_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rv = '{base: 30, len: 5, rdy_pat: 16'hFFFF, wb_start: 0, wb_len: 0, restart: 0, exp_first: 30, exp_last: 34, exp_span: 4};
      run_txn(rv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
